// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core (lw, sw, beq, R-type add/sub/and/or/slt).
// Moore state machine plus the ALU decoder and the immediate-format select.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       instr_done,
    output logic       illegal
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_ALUWB, S_BEQ
    } state_t;

    state_t     r_state, w_next;
    logic       w_pc_update, w_branch, w_mem_write, w_ir_write, w_reg_write;
    logic       w_done, w_illegal;
    logic [1:0] w_alu_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_BEQ:       w_next = S_BEQ;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: w_next = S_MEMWB;
            S_EXECR:   w_next = S_ALUWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_done      = 1'b0;
        w_illegal   = 1'b0;
        w_alu_op    = 2'b00;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_update = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (op != OP_LW && op != OP_SW && op != OP_R && op != OP_BEQ) begin
                    w_illegal = 1'b1;
                    w_done    = 1'b1;
                end
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
                w_done      = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                w_alu_op  = 2'b10;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                w_alu_op  = 2'b01;
                w_branch  = 1'b1;
                w_done    = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated by rst so an in-flight write is dropped the moment reset rises.
    assign pc_write   = ~rst & (w_pc_update | (w_branch & zero));
    assign mem_write  = ~rst & w_mem_write;
    assign ir_write   = ~rst & w_ir_write;
    assign reg_write  = ~rst & w_reg_write;
    assign instr_done = ~rst & w_done;
    assign illegal    = ~rst & w_illegal;

    always_comb begin
        alu_control = 3'b000;
        case (w_alu_op)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            default: imm_src = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: reset checks, a table of per-instruction vectors,
// reset-abort sequences and random instruction streams against a step-indexed model.
module tb_multicycle_ctrl;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk = 1'b0, rst = 1'b1;
    logic [6:0] op = LW;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0, zero = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] res, sa, sb;
        logic [2:0] alu;
        logic [1:0] imm;
        logic       done, ill;
    } out_t;

    out_t act;
    assign act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                  alu_src_a, alu_src_b, alu_control, imm_src, instr_done, illegal};

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] immf(input logic [6:0] o);
        return (o == SW) ? 2'b01 : (o == BEQ) ? 2'b10 : 2'b00;
    endfunction

    function automatic int latency(input logic [6:0] o);
        return (o == LW) ? 5 : (o == SW || o == RT) ? 4 : (o == BEQ) ? 3 : 2;
    endfunction

    function automatic logic [2:0] rfunc(input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return f7 ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs for step k (0 = fetch) of one instruction.
    function automatic out_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                   input logic z, input int k, input logic [1:0] imm);
        out_t e = '0;
        e.imm = imm;
        if (k == 0) begin
            e.irw = 1; e.pcw = 1; e.sb = 2'b10; e.res = 2'b10;
        end else if (k == 1) begin
            e.sa = 2'b01; e.sb = 2'b01;
            if (latency(o) == 2) begin e.ill = 1; e.done = 1; end
        end else if (o == LW || o == SW) begin
            if (k == 2) begin e.sa = 2'b10; e.sb = 2'b01; end
            else if (k == 3) begin
                e.adr = 1;
                if (o == SW) begin e.memw = 1; e.done = 1; end
            end else begin e.res = 2'b01; e.regw = 1; e.done = 1; end
        end else if (o == RT) begin
            if (k == 2) begin e.sa = 2'b10; e.alu = rfunc(f3, f7); end
            else begin e.regw = 1; e.done = 1; end
        end else begin
            e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; e.done = 1;
        end
        return e;
    endfunction

    function automatic out_t rst_vec(input logic [6:0] o);
        out_t e = '0;
        e.sb = 2'b10; e.res = 2'b10; e.imm = immf(o);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
        end
    endtask

    // Starts at posedge+1 in FETCH; runs nsteps cycles (or the whole instruction if <0).
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int nsteps);
        int n = (nsteps < 0) ? latency(o) : nsteps;
        zero = z;
        for (int k = 0; k < n; k++) begin
            logic [1:0] imm;
            if (k == 1) begin op = o; funct3 = f3; funct7b5 = f7; end
            imm = immf(op);
            @(negedge clk);
            chk($sformatf("step%0d_op%b", k, o), 32'(act), 32'(model(o, f3, f7, z, k, imm)));
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        string      name;
        logic [6:0] o;
        logic [2:0] f3;
        logic       f7, z;
        int         lat;
        logic [2:0] alu2;
        logic [1:0] imm;
        logic       pcw_last, ill;
    } tab_t;

    task automatic run_tab(input tab_t t);
        int k = 0;
        logic seen = 0, ill_s = 0, pcw_s = 0;
        logic [2:0] alu_s = 3'bxxx;
        logic [1:0] imm_s = 2'bxx;
        zero = t.z;
        while (!seen && k < 10) begin
            if (k == 1) begin op = t.o; funct3 = t.f3; funct7b5 = t.f7; end
            @(negedge clk);
            if (k == 1) imm_s = imm_src;
            if (k == 2 || (k == 1 && instr_done)) alu_s = alu_control;
            ill_s |= illegal;
            if (instr_done) begin seen = 1; pcw_s = pc_write; end
            @(posedge clk); #1;
            k++;
        end
        chk({t.name, "_lat"}, k, t.lat);
        chk({t.name, "_alu"}, 32'(alu_s), 32'(t.alu2));
        chk({t.name, "_imm"}, 32'(imm_s), 32'(t.imm));
        chk({t.name, "_pcw"}, 32'(pcw_s), 32'(t.pcw_last));
        chk({t.name, "_ill"}, 32'(ill_s), 32'(t.ill));
    endtask

    // Raise rst in the cycle after nsteps steps and confirm the pending write is dropped.
    task automatic abort(input string name, input logic [6:0] o, input int nsteps);
        run_instr(o, 3'b000, 1'b0, 1'b0, nsteps);
        #1;
        chk({name, "_pre"}, 32'(mem_write | reg_write), 32'd1);
        rst = 1'b1; #1;
        chk({name, "_rst"}, 32'(act), 32'(rst_vec(o)));
        @(posedge clk); #1;
        chk({name, "_hold"}, 32'(act), 32'(rst_vec(o)));
        rst = 1'b0; #1;
        chk({name, "_fetch"}, 32'({ir_write, pc_write}), 32'b11);
    endtask

    tab_t tab[10];

    initial begin
        tab[0] = '{"lw",   LW,  3'b000, 1'b0, 1'b0, 5, 3'b000, 2'b00, 1'b0, 1'b0};
        tab[1] = '{"sw",   SW,  3'b010, 1'b0, 1'b0, 4, 3'b000, 2'b01, 1'b0, 1'b0};
        tab[2] = '{"add",  RT,  3'b000, 1'b0, 1'b0, 4, 3'b000, 2'b00, 1'b0, 1'b0};
        tab[3] = '{"sub",  RT,  3'b000, 1'b1, 1'b0, 4, 3'b001, 2'b00, 1'b0, 1'b0};
        tab[4] = '{"and",  RT,  3'b111, 1'b0, 1'b0, 4, 3'b010, 2'b00, 1'b0, 1'b0};
        tab[5] = '{"or",   RT,  3'b110, 1'b0, 1'b0, 4, 3'b011, 2'b00, 1'b0, 1'b0};
        tab[6] = '{"slt",  RT,  3'b010, 1'b0, 1'b0, 4, 3'b101, 2'b00, 1'b0, 1'b0};
        tab[7] = '{"beqt", BEQ, 3'b000, 1'b0, 1'b1, 3, 3'b001, 2'b10, 1'b1, 1'b0};
        tab[8] = '{"beqn", BEQ, 3'b000, 1'b0, 1'b0, 3, 3'b001, 2'b10, 1'b0, 1'b0};
        tab[9] = '{"ill",  BAD, 3'b000, 1'b0, 1'b0, 2, 3'b000, 2'b00, 1'b0, 1'b1};

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset", 32'(act), 32'(rst_vec(LW)));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(LW, 3'b000, 1'b0, 1'b0, -1);

        for (int i = 0; i < 10; i++) run_tab(tab[i]);

        abort("mw_abort", SW, 3);
        run_instr(RT, 3'b111, 1'b0, 1'b0, -1);
        abort("wb_abort", LW, 4);
        run_instr(BEQ, 3'b000, 1'b0, 1'b1, -1);

        for (int i = 0; i < 300; i++) begin
            logic [6:0] o;
            case ($urandom_range(0, 4))
                0: o = LW;
                1: o = SW;
                2: o = RT;
                3: o = BEQ;
                default: o = 7'($urandom);
            endcase
            run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control unit for the multicycle RV32I core. It sequences the shared datapath (PC, instruction register, register file, ALU, unified memory, sign extender) through fetch, decode, execute, memory and writeback steps. It supports lw, sw, beq and R-type add/sub/and/or/slt. It sits between the instruction register and the datapath select/enable lines, and it also drives the immediate-format select consumed by the immediate generator.

## Interface
- No parameters; opcode and funct encodings are fixed RV32I values.
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU zero flag
- pc_write  out  1  PC load enable
- adr_src  out  1  memory address mux: 0=PC, 1=ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  IR and OldPC load enable
- reg_write  out  1  register file write enable
- result_src  out  2  result mux: 00=ALUOut, 01=memory data, 10=ALU result
- alu_src_a  out  2  00=PC, 01=OldPC, 10=register A
- alu_src_b  out  2  00=register B, 01=immediate, 10=constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  00=I, 01=S, 10=B format
- instr_done  out  1  one-cycle pulse in the last cycle of every instruction
- illegal  out  1  one-cycle pulse in DECODE when op is unsupported

## Operation
- Moore FSM with 9 states. Outputs depend on state only, except pc_write (beq) and alu_control/imm_src (decoded from IR fields).
- Defaults: all enables 0, selects 00, alu_op 00 (add).
- FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, result_src=10, pc_write=1. Next state is DECODE.
- DECODE: alu_src_a=01, alu_src_b=01 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 1100011 → BEQ
  - any other op → FETCH with illegal=1 and instr_done=1
- MEMADR: alu_src_a=10, alu_src_b=01. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src=1, result_src=00. Next state is MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next state is FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1, instr_done=1. Next state is FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next state is ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Next state is FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, instr_done=1. Next state is FETCH.
- pc_write = pc_update | (branch & zero).
- ALU decoder:
  - alu_op 00 → add
  - alu_op 01 → sub
  - alu_op 10 by funct3:
    - 000 → sub if {op[5],funct7b5}=11, else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - others → add
- imm_src from op: 0000011→00, 0100011→01, 1100011→10, any other op→00. Valid in every state; the datapath samples it only in DECODE and MEMADR.

## Timing
- rst asserted: state forced to FETCH immediately (async). While rst=1, pc_write, ir_write, reg_write, mem_write, instr_done and illegal are forced to 0. Selects show FETCH values: adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, alu_control=000.
- First rising edge after rst deasserts is a normal FETCH cycle.
- Instruction latency, FETCH cycle through the instr_done cycle inclusive:
  - lw 5
  - sw 4
  - R-type 4
  - beq 3
  - illegal 2
- Register file and memory writes occur on the clk edge that ends MEMWB/ALUWB/MEMWRITE.
- beq: zero is sampled combinationally in BEQ. A taken branch loads PC from ALUOut on the edge leaving BEQ. A not-taken branch leaves PC at PC+4 from FETCH.
- op, funct3 and funct7b5 change only after a FETCH edge. The FSM must not depend on them in FETCH.
- rst asserted mid-instruction (any state): abort with no further write enables. A pending MEMWRITE/MEMWB write must not occur if rst rises before that edge.
- No stall input. Memory is single-cycle.

## Test plan
- Reset: hold rst 3 cycles with op=0000011 → all enables 0, state FETCH. First cycle after release: ir_write=1, pc_write=1.
- lw (op=0000011): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB → reg_write=1 only in cycle 5, result_src=01, imm_src=00, instr_done in cycle 5.
- sw (op=0100011): 4 cycles → mem_write=1 and adr_src=1 in cycle 4 only, imm_src=01, reg_write never 1.
- R-type with funct3=000, funct7b5=1 → alu_control=001 in EXECR. With funct3=111 → 010. With funct3=010 → 101. reg_write in cycle 4.
- beq (op=1100011) with zero=1 → pc_write=1 in cycle 3. With zero=0 → pc_write=0 in cycle 3. alu_control=001, imm_src=10.
- Unsupported op=1111111 → illegal and instr_done pulse in DECODE, return to FETCH. Separately, rst asserted in MEMWRITE → mem_write drops to 0 at once and state is FETCH.
